sys_ctrl_host: RTL
==================

SYS_CTRL_HOST -- requirements
Module: sys_ctrl_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning the maximum number of clk cycles to wait for a read-response byte.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have port cmd_op, input, 3 bits: 0 halt, 1 resume, 2 write, 3 read, 4 reset CPU.
REQ-007 SHALL have port cmd_addr, input, 16 bits: target CPU bus address.
REQ-008 SHALL have port cmd_wdata, input, 8 bits: write data.
REQ-009 SHALL have port tx_start, output, 1 bit: one-cycle pulse to the byte UART transmitter.
REQ-010 SHALL have port tx_data, output, 8 bits: byte to transmit; held stable until tx_done.
REQ-011 SHALL have port tx_done, input, 1 bit: one-cycle pulse when a byte has finished sending.
REQ-012 SHALL have port rx_valid, input, 1 bit: one-cycle pulse when a received byte is available.
REQ-013 SHALL have port rx_data, input, 8 bits: received byte.
REQ-014 SHALL have port rsp_done, output, 1 bit: one-cycle pulse when a command completes.
REQ-015 SHALL have port rsp_rdata, output, 8 bits: last read byte; holds its value until the next read completes.
REQ-016 SHALL have port rsp_err, output, 2 bits, valid with rsp_done: 0 ok, 1 illegal opcode, 2 read timeout.

Function
REQ-017 SHALL accept a command when cmd_valid is high and the FSM is in IDLE, capturing op, addr and wdata into registers that are not affected by input changes afterwards.
REQ-018 SHALL send the following byte sequences. Halt: 0x00. Resume: 0x01. Reset: 0x04. Write: 0x02, addr[15:8], addr[7:0], wdata. Read: 0x03, addr[15:8], addr[7:0].
REQ-019 SHALL use FSM states IDLE, SEND, WAIT_TX, WAIT_RSP and DONE, with a 2-bit byte index selecting tx_data.
REQ-020 SHALL, in SEND, assert tx_start for exactly 1 cycle with tx_data valid, then move to WAIT_TX.
REQ-021 SHALL, in WAIT_TX, wait for tx_done; on tx_done, if more bytes remain it SHALL increment the index and return to SEND.
REQ-022 SHALL, in WAIT_TX on tx_done after the last byte, go to WAIT_RSP for a read and to DONE for any other command.
REQ-023 SHALL make tx_start for the first byte occur on the cycle after acceptance, giving a minimum gap of 1 cycle between tx_done and the next tx_start.
REQ-024 SHALL, in WAIT_RSP, clear a 16-bit counter on entry and increment it every cycle.
REQ-025 SHALL, on rx_valid in WAIT_RSP, load rsp_rdata with rx_data and go to DONE with err=0.
REQ-026 SHALL, when the WAIT_RSP counter reaches TIMEOUT_CYCLES-1 with no rx_valid, go to DONE with err=2 and leave rsp_rdata unchanged.
REQ-027 SHALL give rx_valid priority over timeout when both occur on the same cycle.
REQ-028 SHALL ignore rx_valid in every state except WAIT_RSP.
REQ-029 SHALL ignore tx_done outside WAIT_TX.
REQ-030 SHALL treat cmd_op values 5..7 as illegal: accept them, send no bytes, and go directly to DONE with err=1.
REQ-031 SHALL, in DONE, pulse rsp_done for 1 cycle, then return to IDLE; cmd_ready SHALL be low during DONE.
REQ-032 SHALL have no timeout in WAIT_TX; tx_done is guaranteed by the transmitter.

Reset
REQ-033 SHALL, while rst is high, force: state IDLE, index 0, counter 0, tx_start 0, tx_data 0x00, rsp_done 0, rsp_err 0, rsp_rdata 0x00; cmd_ready SHALL be high once rst is released.
REQ-034 SHALL, on rst asserted mid-command, abort the command immediately, issue no rsp_done for it, and produce no further tx_start.

Verification
REQ-035 SHALL pass scenario write: op=2, addr=0x8123, wdata=0x5A, with tx_done returned 10 cycles after each tx_start -> tx bytes 02,81,23,5A; rsp_done once with err=0.
REQ-036 SHALL pass scenario read: op=3, addr=0xC000, rx_valid with rx_data=0xA7 20 cycles after the last tx_done -> tx bytes 03,C0,00; rsp_rdata=0xA7; err=0.
REQ-037 SHALL pass scenario timeout: read with TIMEOUT_CYCLES=100 and no rx_valid -> rsp_done exactly 100 cycles after WAIT_RSP entry; err=2; rsp_rdata unchanged.
REQ-038 SHALL pass scenario illegal/simple opcodes: op=6 -> no tx_start, rsp_done with err=1; op=0, op=1 and op=4 -> single bytes 00, 01 and 04 respectively.
REQ-039 SHALL pass scenario backpressure: cmd_valid held high through a command -> second command accepted only after the DONE cycle; stray rx_valid during WAIT_TX is ignored.
REQ-040 SHALL pass scenario reset: rst asserted during WAIT_TX of byte 2 of a write -> outputs at reset values, no rsp_done; a subsequent command starts from byte 0.

Source files
------------

// File: rtl/sys_ctrl_host.sv
// sys_ctrl_host: byte-serial debug command host for a CPU (halt/resume/write/read/reset).
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   cmd_valid/ready/op/addr/wdata  command handshake and payload
//   tx_start/tx_data/tx_done     byte UART transmitter handshake
//   rx_valid/rx_data             received byte from the CPU side
//   rsp_done/rsp_rdata/rsp_err   completion pulse, last read byte, status
module sys_ctrl_host #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rsp_done,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_err
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RSP, DONE} state_t;
    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_cnt;
    logic [2:0]  r_op;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_rsp_done;
    logic [7:0]  r_rsp_rdata;
    logic [1:0]  r_rsp_err;
    logic [1:0]  w_last;
    logic [1:0]  w_nidx;
    logic [7:0]  w_nbyte;
    // index of the final byte: write sends 4, read 3, everything else 1
    assign w_last    = (r_op == 3'd2) ? 2'd3 : (r_op == 3'd3) ? 2'd2 : 2'd0;
    assign w_nidx    = r_idx + 2'd1;
    // byte 0 is always the opcode and is loaded at acceptance, so only 1..3 come from here
    assign w_nbyte   = (w_nidx == 2'd1) ? r_addr[15:8] : (w_nidx == 2'd2) ? r_addr[7:0] : r_wdata;
    assign cmd_ready = (r_state == IDLE);
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign rsp_done  = r_rsp_done;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 16'd0;
            r_op        <= 3'd0;
            r_addr      <= 16'd0;
            r_wdata     <= 8'd0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_rsp_done  <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_rsp_err   <= 2'd0;
        end else begin
            r_tx_start <= 1'b0;
            r_rsp_done <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op    <= cmd_op;
                    r_addr  <= cmd_addr;
                    r_wdata <= cmd_wdata;
                    r_idx   <= 2'd0;
                    if (cmd_op > 3'd4) begin
                        r_state    <= DONE;
                        r_rsp_done <= 1'b1;
                        r_rsp_err  <= 2'd1;
                    end else begin
                        r_state    <= SEND;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= {5'd0, cmd_op};
                    end
                end
                SEND: r_state <= WAIT_TX;
                WAIT_TX: if (tx_done) begin
                    if (r_idx == w_last) begin
                        r_cnt <= 16'd0;
                        if (r_op == 3'd3) begin
                            r_state <= WAIT_RSP;
                        end else begin
                            r_state    <= DONE;
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 2'd0;
                        end
                    end else begin
                        r_idx      <= w_nidx;
                        r_tx_data  <= w_nbyte;
                        r_tx_start <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                WAIT_RSP: begin
                    r_cnt <= r_cnt + 16'd1;
                    // a byte arriving on the timeout cycle still counts as a good response
                    if (rx_valid) begin
                        r_rsp_rdata <= rx_data;
                        r_rsp_err   <= 2'd0;
                        r_rsp_done  <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        r_rsp_err  <= 2'd2;
                        r_rsp_done <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
